// File: rtl/repetition3_tx.sv
`default_nettype none
// ============================================================================
// Module   : repetition3_tx
// Purpose  : Serial transmitter for a 3x repetition code. Each accepted byte
//            is sent as a frame of logical bits (start bit '1', then the 8
//            data bits LSB first, then an optional even-parity bit). Every
//            logical bit is held on sout for 3 consecutive cycles so a
//            majority-vote receiver can correct one bad symbol per triplet.
// Ports    : clk      - clock, all state changes on the rising edge
//            rst_n    - synchronous active-low reset
//            in_val   - producer has a byte on in_data
//            in_data  - payload byte, sampled only on the accepting edge
//            in_rdy   - block is idle and can accept a byte
//            sout     - serial symbol line, 0 when idle
//            sout_val - sout carries a frame symbol this cycle
//            done     - one-cycle pulse on the last symbol of a frame
// Config   : define REPETITION3_TX_PARITY_EN to append the even-parity bit
//            (frame 30 cycles); otherwise the frame is 27 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module repetition3_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_val,
  input  logic [7:0] in_data,
  output logic       in_rdy,
  output logic       sout,
  output logic       sout_val,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_DATA   = 2'd2,
    S_PARITY = 2'd3
  } state_t;

  localparam logic [1:0] C_REP_LAST = 2'd2;
  localparam logic [1:0] C_REP_PRE  = 2'd1;  // repeat index one before the last
  localparam logic [2:0] C_BIT_LAST = 3'd7;

  state_t     r_state;
  logic [1:0] r_rep;
  logic [2:0] r_bit;
  logic [7:0] r_shift;

  // All outputs are registered: each transition loads the output values the
  // next cycle must show. The shift register rotates rather than shifts, so
  // its XOR reduction stays equal to the parity of the latched byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rep    <= 2'd0;
      r_bit    <= 3'd0;
      r_shift  <= 8'd0;
      in_rdy   <= 1'b1;
      sout     <= 1'b0;
      sout_val <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_val && in_rdy) begin
            r_shift  <= in_data;
            r_rep    <= 2'd0;
            r_bit    <= 3'd0;
            r_state  <= S_START;
            in_rdy   <= 1'b0;
            sout     <= 1'b1;       // start bit is logical 1
            sout_val <= 1'b1;
          end
        end

        S_START: begin
          if (r_rep == C_REP_LAST) begin
            r_rep   <= 2'd0;
            r_state <= S_DATA;
            sout    <= r_shift[0];
          end else begin
            r_rep <= r_rep + 2'd1;
          end
        end

        S_DATA: begin
          if (r_rep == C_REP_LAST) begin
            r_rep <= 2'd0;
            if (r_bit == C_BIT_LAST) begin
`ifdef REPETITION3_TX_PARITY_EN
              r_state <= S_PARITY;
              sout    <= ^r_shift;
`else
              r_state  <= S_IDLE;
              r_bit    <= 3'd0;
              in_rdy   <= 1'b1;
              sout     <= 1'b0;
              sout_val <= 1'b0;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {r_shift[0], r_shift[7:1]};
              sout    <= r_shift[1];  // next data bit, visible after rotation
            end
          end else begin
            r_rep <= r_rep + 2'd1;
`ifndef REPETITION3_TX_PARITY_EN
            // Entering the final repeat of bit 7 is the last frame cycle.
            done <= (r_bit == C_BIT_LAST) && (r_rep == C_REP_PRE);
`endif
          end
        end

`ifdef REPETITION3_TX_PARITY_EN
        S_PARITY: begin
          if (r_rep == C_REP_LAST) begin
            r_rep    <= 2'd0;
            r_bit    <= 3'd0;
            r_state  <= S_IDLE;
            in_rdy   <= 1'b1;
            sout     <= 1'b0;
            sout_val <= 1'b0;
          end else begin
            r_rep <= r_rep + 2'd1;
            done  <= (r_rep == C_REP_PRE);
          end
        end
`endif

        default: begin
          r_state  <= S_IDLE;
          r_rep    <= 2'd0;
          r_bit    <= 3'd0;
          in_rdy   <= 1'b1;
          sout     <= 1'b0;
          sout_val <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_repetition3_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_repetition3_tx
// Purpose  : Self-checking bench for repetition3_tx. A frame-level model
//            (queue of expected symbols per accepted byte) is compared with
//            the DUT every cycle; a majority voter recovers each frame and
//            checks it against the byte that was sent. Directed cases pin
//            the model with hand-computed literal frames.
// Config   : honours REPETITION3_TX_PARITY_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_repetition3_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_val = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_rdy;
  logic       sout;
  logic       sout_val;
  logic       done;

`ifdef REPETITION3_TX_PARITY_EN
  localparam int FL = 30;
  localparam int NB = 10;
`else
  localparam int FL = 27;
  localparam int NB = 9;
`endif

  repetition3_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (in_val),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .sout     (sout),
    .sout_val (sout_val),
    .done     (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: expected {sout, sout_val, done} for each remaining frame cycle.
  logic [2:0] exp_q[$];
  logic [7:0] cur_byte = 8'd0;
  bit         chk_en = 1'b0;
  logic [3:0] m_exp;

  // Voter state
  logic       sym[0:31];
  int         nsym = 0;
  int         done_cnt = 0;
  logic [7:0] last_rx = 8'd0;
  int         gap_run = 0;
  int         last_gap = 0;
  logic [15:0] vb;
  logic [15:0] expv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [7:0] d);
    logic [9:0] bits;
    bits = 10'd0;
    bits[0] = 1'b1;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef REPETITION3_TX_PARITY_EN
    bits[9] = ^d;
`endif
    for (int j = 0; j < NB; j++)
      for (int r = 0; r < 3; r++)
        exp_q.push_back({bits[j], 1'b1, (j == NB-1 && r == 2) ? 1'b1 : 1'b0});
  endfunction

  // Model update at the edge, compare and vote 1 time unit later.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      nsym   = 0;
      chk_en = 1'b1;
    end else if (exp_q.size() == 0) begin
      if (in_val) begin
        push_frame(in_data);
        cur_byte = in_data;
      end
    end else begin
      void'(exp_q.pop_front());
    end
    #1;
    if (chk_en) begin
      m_exp = (exp_q.size() == 0) ? 4'b1000 : {1'b0, exp_q[0]};
      check("cycle", {28'd0, in_rdy, sout, sout_val, done}, {28'd0, m_exp});

      if (sout_val) begin
        if (nsym < 32) sym[nsym] = sout;
        nsym++;
        if (gap_run > 0) last_gap = gap_run;
        gap_run = 0;
      end else begin
        gap_run++;
      end

      if (done) begin
        done_cnt++;
        vb = 16'd0;
        for (int j = 0; j < NB; j++)
          vb[j] = (sym[3*j] & sym[3*j+1]) | (sym[3*j] & sym[3*j+2]) | (sym[3*j+1] & sym[3*j+2]);
        expv = 16'd0;
        expv[0] = 1'b1;
        expv[8:1] = cur_byte;
`ifdef REPETITION3_TX_PARITY_EN
        expv[9] = ^cur_byte;
`endif
        last_rx = vb[8:1];
        check("loopback", {nsym[15:0], vb}, {16'(FL), expv});
        nsym = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (!in_rdy && n < 64) begin
      tick;
      n++;
    end
    check("idle_wait", {31'd0, in_rdy}, 32'd1);
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 64) begin
      tick;
      n++;
    end
    check("done_wait", done_cnt - base, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    wait_idle;
    in_val  = 1'b1;
    in_data = d;
    tick;
    in_val  = 1'b0;
  endtask

  task automatic send_capture(input logic [7:0] d, output logic [29:0] sv,
                              output logic [29:0] dv, output logic [29:0] vv,
                              output logic rdy_after);
    sv = '0;
    dv = '0;
    vv = '0;
    wait_idle;
    in_val  = 1'b1;
    in_data = d;
    for (int n = 1; n <= FL; n++) begin
      tick;
      if (n == 1) in_val = 1'b0;
      sv[FL-n] = sout;
      dv[FL-n] = done;
      vv[FL-n] = sout_val;
    end
    tick;
    rdy_after = in_rdy;
  endtask

  logic [29:0] sv, dv, vv;
  logic        rdy_after;
  int          base;
  int          n;

  initial begin
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    check("reset_state", {28'd0, in_rdy, sout, sout_val, done}, 32'h8);

    // Single frame 0xA5
    send_capture(8'hA5, sv, dv, vv, rdy_after);
`ifdef REPETITION3_TX_PARITY_EN
    check("a5_sout", {2'd0, sv}, {2'd0, 30'b111111000111000000111000111000});
    check("a5_val",  {2'd0, vv}, 32'h3FFF_FFFF);
`else
    check("a5_sout", {2'd0, sv}, {5'd0, 27'b111111000111000000111000111});
    check("a5_val",  {2'd0, vv}, 32'h07FF_FFFF);
`endif
    check("a5_done", {2'd0, dv}, 32'd1);
    check("a5_rdy_after", {31'd0, rdy_after}, 32'd1);

    // 0x07: three ones, parity bit 1 when enabled
    send_capture(8'h07, sv, dv, vv, rdy_after);
`ifdef REPETITION3_TX_PARITY_EN
    check("x07_tail", {29'd0, sv[2:0]}, 32'h7);
`else
    check("x07_tail", {29'd0, sv[2:0]}, 32'h0);
`endif
    check("x07_done", {2'd0, dv}, 32'd1);

    // Inputs toggling while busy must not disturb the latched byte
    wait_idle;
    base    = done_cnt;
    in_val  = 1'b1;
    in_data = 8'h3C;
    tick;
    n = 0;
    while (done_cnt == base && n < 40) begin
      in_data = n[0] ? 8'hFF : 8'h00;
      tick;
      n++;
    end
    in_val = 1'b0;
    check("ignored_rx", {24'd0, last_rx}, 32'h3C);
    wait_idle;

    // Back-to-back frames
    wait_idle;
    base    = done_cnt;
    in_val  = 1'b1;
    in_data = 8'h01;
    tick;
    n = 0;
    while (!in_rdy && n < 40) begin
      tick;
      n++;
    end
    check("b2b_first_rx", {24'd0, last_rx}, 32'h01);
    in_data = 8'h80;
    tick;
    in_val = 1'b0;
    wait_done(base + 1);
    check("b2b_second_rx", {24'd0, last_rx}, 32'h80);
    check("b2b_gap", last_gap, 32'd1);

    // Reset in the middle of a frame
    wait_idle;
    base    = done_cnt;
    in_val  = 1'b1;
    in_data = 8'hC3;
    tick;
    in_val  = 1'b0;
    repeat (9) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("rst_mid_out", {28'd0, in_rdy, sout, sout_val, done}, 32'h8);
    repeat (30) tick;
    check("rst_no_done", done_cnt - base, 32'd0);
    base = done_cnt;
    send_byte(8'h5A);
    wait_done(base);
    check("rst_clean_rx", {24'd0, last_rx}, 32'h5A);

    // Loopback over every byte value
    wait_idle;
    base = done_cnt;
    for (int b = 0; b < 256; b++) send_byte(b[7:0]);
    wait_idle;
    check("loopback_count", done_cnt - base, 32'd256);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      in_val  = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      rst_n   = ($urandom_range(0, 99) != 0);
      tick;
    end
    rst_n  = 1'b1;
    in_val = 1'b0;
    wait_idle;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
